// File: rtl/mii_rx_pkg.sv
// Shared types and constants for the MII/GMII receive frame assembler.
// Symbols are zero-extended to a byte so both widths compare the same way.
package mii_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } rx_state_t;

    localparam int ERR_RXERR   = 0;
    localparam int ERR_DRIBBLE = 1;
    localparam int ERR_SHORT   = 2;
    localparam int ERR_LONG    = 3;

    localparam logic [3:0] PRE_MII  = 4'h5;
    localparam logic [3:0] SFD_MII  = 4'hD;
    localparam logic [7:0] PRE_GMII = 8'h55;
    localparam logic [7:0] SFD_GMII = 8'hD5;

    function automatic logic [7:0] pre_sym(input int dw);
        return (dw == 4) ? {4'h0, PRE_MII} : PRE_GMII;
    endfunction

    function automatic logic [7:0] sfd_sym(input int dw);
        return (dw == 4) ? {4'h0, SFD_MII} : SFD_GMII;
    endfunction

endpackage

// File: rtl/mii_rx_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module mii_rx_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && count != '1)
            count <= count + W'(1);
    end

endmodule

// File: rtl/mii_rx_frame_assembler.sv
// Receive front end: strips preamble/SFD, packs MII nibbles or GMII bytes into
// a byte stream with sof/eof, frame length, error classification and counters.
module mii_rx_frame_assembler
    import mii_rx_pkg::*;
#(
    parameter int DW      = 4,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 11,
    parameter int CNT_W   = 16
) (
    input  logic             mrx_clk_pad_i,
    input  logic             rst_i,
    input  logic [DW-1:0]    mrxd_pad_i,
    input  logic             mrxdv_pad_i,
    input  logic             mrxerr_pad_i,
    output logic [7:0]       byte_o,
    output logic             byte_vld_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic             err_o,
    output logic [3:0]       err_code_o,
    output logic [LEN_W-1:0] len_o,
    output logic [CNT_W-1:0] frames_ok_o,
    output logic [CNT_W-1:0] frames_bad_o
);

    if (DW != 4 && DW != 8) begin : g_dw_check
        $error("mii_rx_frame_assembler: DW must be 4 or 8");
    end
    if ((2 ** LEN_W) <= MAX_LEN + 1) begin : g_len_check
        $error("mii_rx_frame_assembler: LEN_W cannot hold MAX_LEN+1");
    end

    localparam logic [7:0]       PRE     = pre_sym(DW);
    localparam logic [7:0]       SFD     = sfd_sym(DW);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);

    rx_state_t        state, state_nxt;
    logic [7:0]       din;
    logic [3:0]       nib_lo;
    logic             nib_pend;
    logic [7:0]       hold;
    logic             hold_vld, hold_first;
    logic [LEN_W-1:0] cnt;
    logic [3:0]       flags, end_flags;
    logic             sfd_hit, beat, frame_end, byte_done;
    logic [7:0]       byte_val;

    assign din = 8'(mrxd_pad_i);

    always_ff @(posedge mrx_clk_pad_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sfd_hit   = 1'b0;
        beat      = 1'b0;
        frame_end = 1'b0;
        case (state)
            S_IDLE:
                if (mrxdv_pad_i) state_nxt = S_PREAMBLE;
            S_PREAMBLE:
                if (!mrxdv_pad_i) begin
                    state_nxt = S_IDLE;
                end else if (din == SFD) begin
                    state_nxt = S_DATA;
                    sfd_hit   = 1'b1;
                end else if (din != PRE) begin
                    state_nxt = S_DROP;
                end
            S_DATA:
                if (mrxdv_pad_i) begin
                    beat = 1'b1;
                end else begin
                    frame_end = 1'b1;
                    state_nxt = S_IDLE;
                end
            S_DROP:
                if (!mrxdv_pad_i) state_nxt = S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        byte_done = beat && (DW == 8 || nib_pend);
        byte_val  = (DW == 8) ? din : {din[3:0], nib_lo};
        end_flags = flags;
        if (nib_pend)      end_flags[ERR_DRIBBLE] = 1'b1;
        if (cnt < LEN_MIN) end_flags[ERR_SHORT]   = 1'b1;
    end

    // Completed bytes wait in 'hold' so the final one can be tagged with eof.
    always_ff @(posedge mrx_clk_pad_i) begin
        if (rst_i) begin
            nib_lo     <= '0;
            nib_pend   <= 1'b0;
            hold       <= '0;
            hold_vld   <= 1'b0;
            hold_first <= 1'b0;
            cnt        <= '0;
            flags      <= '0;
            byte_o     <= '0;
            byte_vld_o <= 1'b0;
            sof_o      <= 1'b0;
            eof_o      <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= '0;
            len_o      <= '0;
        end else begin
            byte_vld_o <= 1'b0;
            sof_o      <= 1'b0;
            eof_o      <= 1'b0;
            if (sfd_hit) begin
                cnt      <= '0;
                flags    <= '0;
                hold_vld <= 1'b0;
                nib_pend <= 1'b0;
            end
            if (beat) begin
                if (mrxerr_pad_i) flags[ERR_RXERR] <= 1'b1;
                if (DW == 4) begin
                    nib_pend <= ~nib_pend;
                    if (!nib_pend) nib_lo <= din[3:0];
                end
                if (byte_done) begin
                    if (cnt != LEN_SAT) cnt <= cnt + LEN_W'(1);
                    if (cnt < LEN_MAX) begin
                        hold       <= byte_val;
                        hold_vld   <= 1'b1;
                        hold_first <= !hold_vld;
                        if (hold_vld) begin
                            byte_o     <= hold;
                            byte_vld_o <= 1'b1;
                            sof_o      <= hold_first;
                        end
                    end else begin
                        flags[ERR_LONG] <= 1'b1;
                    end
                end
            end
            // An empty frame still reports once, as a zero byte with sof and eof.
            if (frame_end) begin
                byte_o     <= hold_vld ? hold : 8'h00;
                byte_vld_o <= 1'b1;
                sof_o      <= hold_vld ? hold_first : 1'b1;
                eof_o      <= 1'b1;
                len_o      <= cnt;
                err_code_o <= end_flags;
                err_o      <= |end_flags;
                hold_vld   <= 1'b0;
            end
        end
    end

    mii_rx_sat_counter #(.W(CNT_W)) u_cnt_ok (
        .clk   (mrx_clk_pad_i),
        .rst   (rst_i),
        .inc   (frame_end && !(|end_flags)),
        .count (frames_ok_o)
    );

    mii_rx_sat_counter #(.W(CNT_W)) u_cnt_bad (
        .clk   (mrx_clk_pad_i),
        .rst   (rst_i),
        .inc   (frame_end && (|end_flags)),
        .count (frames_bad_o)
    );

endmodule
